// File: rtl/instr_fetch_unit_if.sv
// Instruction bus and decode-side handshake bundle for instr_fetch_unit.
// master = fetch unit, slave = bus/decode side.
interface instr_fetch_unit_if;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        active;
    logic        fetch_err;

    modport master (
        output address, read, byteenable, instr_word, instr_pc, instr_valid, active, fetch_err,
        input  waitrequest, readdata, instr_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  address, read, byteenable, instr_word, instr_pc, instr_valid, active, fetch_err,
        output waitrequest, readdata, instr_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, Avalon-style read master, valid/ready to decode.
// Optional misaligned-target trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    // state   | meaning
    // START   | one idle cycle after reset
    // FETCH   | read issued, waiting for waitrequest low
    // HOLD    | instruction presented to decode
    // HALTED  | stopped until reset
    typedef enum logic [1:0] {ST_START, ST_FETCH, ST_HOLD, ST_HALTED} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_read;
    logic [31:0] r_instr_word;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_active;
    logic        r_fetch_err;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    logic        w_handshake;
    logic [31:0] w_next_raw;
    logic [31:0] w_next_pc;
    logic        w_misaligned;

    always_comb begin
        w_handshake = (r_state == ST_HOLD) && r_instr_valid && bus.instr_ready;
        if (bus.redirect_valid)
            w_next_raw = bus.redirect_target;
        else if (r_pend_valid)
            w_next_raw = r_pend_target;
        else
            w_next_raw = r_pc + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
        w_next_pc    = w_next_raw;
        w_misaligned = |w_next_raw[1:0];
`else
        w_next_pc    = {w_next_raw[31:2], 2'b00};
        w_misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_START;
            r_pc          <= RESET_VECTOR;
            r_read        <= 1'b0;
            r_instr_word  <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_instr_valid <= 1'b0;
            r_active      <= 1'b1;
            r_fetch_err   <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else begin
            // Redirects that arrive outside a handshake wait for the next PC update.
            if (bus.redirect_valid && (r_state != ST_HALTED) && !w_handshake) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= bus.redirect_target;
            end
            case (r_state)
                ST_START: begin
                    r_read  <= 1'b1;
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!bus.waitrequest) begin
                        r_instr_word  <= bus.readdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_read        <= 1'b0;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_instr_valid <= 1'b0;
                        r_pend_valid  <= 1'b0;
                        if (w_misaligned) begin
                            r_fetch_err <= 1'b1;
                            r_active    <= 1'b0;
                            r_state     <= ST_HALTED;
                        end else if (w_next_pc == HALT_ADDR) begin
                            r_pc     <= w_next_pc;
                            r_active <= 1'b0;
                            r_state  <= ST_HALTED;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_read  <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    r_read        <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_active      <= 1'b0;
                end
                default: r_state <= ST_HALTED;
            endcase
        end
    end

    assign bus.address     = r_pc;
    assign bus.read        = r_read;
    assign bus.byteenable  = 4'hF;
    assign bus.instr_word  = r_instr_word;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.active      = r_active;
    assign bus.fetch_err   = r_fetch_err;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: bus slave stimulus with a
// scoreboard of fetched {pc, word} pairs checked at each decode handshake.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus_if ();

    instr_fetch_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic [31:0] exp_pend_tgt;
    bit          halted;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input bit redir, input logic [31:0] tgt);
        logic [31:0] n;
        n = redir ? tgt : (exp_pend ? exp_pend_tgt : exp_pc + 32'd4);
`ifndef FETCH_ALIGN_CHECK_EN
        n[1:0] = 2'b00;
`endif
        return n;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.waitrequest     = 1'b0;
        bus_if.instr_ready     = 1'b1;
        bus_if.redirect_valid  = 1'b0;
        bus_if.redirect_target = 32'd0;
        bus_if.readdata        = 32'd0;
        step();
        step();
        chk("rst_read",   bus_if.read,        0);
        chk("rst_valid",  bus_if.instr_valid, 0);
        chk("rst_active", bus_if.active,      1);
        chk("rst_err",    bus_if.fetch_err,   0);
        chk("rst_addr",   bus_if.address,     32'hBFC00000);
        chk("rst_word",   bus_if.instr_word,  0);
        chk("rst_ipc",    bus_if.instr_pc,    0);
        chk("rst_be",     bus_if.byteenable,  32'hF);
        exp_pc   = 32'hBFC00000;
        exp_pend = 1'b0;
        sb_q.delete();
        rst_n = 1'b1;
        step();
    endtask

    // Precondition: DUT is in FETCH (checked). Ends after the handshake edge.
    task automatic do_fetch(input logic [31:0] data, input int waits, input int stall,
                            input bit redir_fetch, input bit redir_hs, input logic [31:0] tgt,
                            output bit is_halted);
        logic [63:0] e;
        logic [31:0] n;
        bit          mis;
        chk("fetch_read", bus_if.read, 1);
        chk("fetch_addr", bus_if.address, exp_pc);
        bus_if.waitrequest = 1'b1;
        for (int i = 0; i < waits; i++) begin
            step();
            chk("wait_read",  bus_if.read,        1);
            chk("wait_addr",  bus_if.address,     exp_pc);
            chk("wait_valid", bus_if.instr_valid, 0);
        end
        bus_if.waitrequest     = 1'b0;
        bus_if.readdata        = data;
        bus_if.redirect_valid  = redir_fetch;
        bus_if.redirect_target = tgt;
        bus_if.instr_ready     = 1'b0;
        sb_q.push_back({exp_pc, data});
        if (redir_fetch) begin
            exp_pend     = 1'b1;
            exp_pend_tgt = tgt;
        end
        step();
        bus_if.redirect_valid = 1'b0;
        bus_if.readdata       = 32'hDEADBEEF;
        bus_if.waitrequest    = 1'b1;
        chk("valid",     bus_if.instr_valid, 1);
        chk("read_hold", bus_if.read,        0);
        for (int i = 0; i < stall; i++) begin
            if (redir_fetch && i == 0) begin
                bus_if.redirect_valid  = 1'b1;
                bus_if.redirect_target = tgt + 32'h100;
                exp_pend_tgt           = tgt + 32'h100;
            end
            step();
            bus_if.redirect_valid = 1'b0;
            chk("stall_valid", bus_if.instr_valid, 1);
            chk("stall_read",  bus_if.read,        0);
            chk("stall_word",  bus_if.instr_word,  sb_q[0][31:0]);
            chk("stall_pc",    bus_if.instr_pc,    sb_q[0][63:32]);
        end
        bus_if.instr_ready     = 1'b1;
        bus_if.waitrequest     = 1'b0;
        bus_if.redirect_valid  = redir_hs;
        bus_if.redirect_target = tgt;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("word", bus_if.instr_word, e[31:0]);
            chk("pc",   bus_if.instr_pc,   e[63:32]);
        end
        n        = model_next(redir_hs, tgt);
        exp_pend = 1'b0;
        mis      = |n[1:0];
        is_halted = (n == 32'd0) || mis;
        step();
        bus_if.redirect_valid = 1'b0;
        chk("hs_valid", bus_if.instr_valid, 0);
        if (is_halted) begin
            chk("halt_active", bus_if.active,    0);
            chk("halt_read",   bus_if.read,      0);
            chk("halt_err",    bus_if.fetch_err, {31'd0, mis});
        end else begin
            exp_pc = n;
            chk("run_active", bus_if.active, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        // Boot fetches, zero wait states.
        do_reset();
        do_fetch(32'h24080005, 0, 0, 0, 0, 32'd0, halted);
        do_fetch(32'h24090007, 0, 0, 0, 0, 32'd0, halted);
        // Wait states, then decode back-pressure.
        do_reset();
        do_fetch(32'h11111111, 3, 0, 0, 0, 32'd0, halted);
        do_fetch(32'h22222222, 0, 5, 0, 0, 32'd0, halted);
        // Pending redirect, redirect on handshake, overwritten pending redirect.
        do_fetch(32'h33333333, 1, 0, 1, 0, 32'h00001000, halted);
        do_fetch(32'h44444444, 0, 0, 0, 1, 32'h00001000, halted);
        do_fetch(32'h55555555, 0, 2, 1, 0, 32'h00003000, halted);
        do_fetch(32'h66666666, 0, 0, 0, 0, 32'd0, halted);
        // Wrap 0xFFFFFFFC + 4 = 0 halts; redirects are then ignored.
        do_fetch(32'h77777777, 0, 0, 0, 1, 32'hFFFFFFFC, halted);
        do_fetch(32'h88888888, 2, 0, 0, 0, 32'd0, halted);
        chk("wrap_halted", {31'd0, halted}, 1);
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'h00004000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halted_read",   bus_if.read,        0);
            chk("halted_valid",  bus_if.instr_valid, 0);
            chk("halted_active", bus_if.active,      0);
        end
        bus_if.redirect_valid = 1'b0;
        // Redirect to 0 halts; reset restarts at the reset vector.
        do_reset();
        do_fetch(32'h99999999, 0, 0, 0, 1, 32'h00000000, halted);
        do_reset();
        do_fetch(32'hAAAAAAAA, 0, 0, 0, 1, 32'h00001000, halted);
        // Reset during a stalled fetch abandons the read.
        bus_if.waitrequest = 1'b1;
        step();
        chk("midrst_pre_addr", bus_if.address, 32'h00001000);
        rst_n = 1'b0;
        step();
        chk("midrst_read",  bus_if.read,        0);
        chk("midrst_valid", bus_if.instr_valid, 0);
        chk("midrst_addr",  bus_if.address,     32'hBFC00000);
        // Misaligned redirect target.
        do_reset();
        do_fetch(32'hBBBBBBBB, 0, 0, 0, 1, 32'h00001002, halted);
        if (!halted)
            do_fetch(32'hCCCCCCCC, 0, 0, 0, 0, 32'd0, halted);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
